// File: rtl/aes_block_unpack.sv
`default_nettype none
// ============================================================================
// Module  : aes_block_unpack
// Brief   : Serialises a decrypted 128-bit block MSB-first into a byte stream,
//           trimming padding on the final block of a frame.
// Revision: 1.0
// ============================================================================
module aes_block_unpack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [127:0]     plaintext,
    input  logic             done,
    input  logic             last_in,
    input  logic [4:0]       nbytes_in,
    output logic             unpack_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             len_err,
    output logic [CNT_W-1:0] block_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [3:0]       c_LIM_FULL = 4'd15;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [127:0]     blk_q, blk_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       lim_q, lim_d;
    logic             frame_end_q, frame_end_d;
    logic             len_err_q, len_err_d;
    logic [CNT_W-1:0] block_cnt_q, block_cnt_d;

    logic             w_emit;
    logic             w_at_lim;
    logic             w_xfer;
    logic             w_accept;
    logic             w_len_ok;
    logic [4:0]       w_nb_m1;
    logic [127:0]     w_shifted;

    assign w_emit    = (state_q == ST_EMIT);
    assign w_at_lim  = (idx_q == lim_q);
    assign w_xfer    = w_emit && m_ready;
    assign w_len_ok  = (nbytes_in != 5'd0) && (nbytes_in <= 5'd16);
    assign w_nb_m1   = nbytes_in - 5'd1;
    // Shifting the held block left puts byte idx at the top, avoiding a variable part-select.
    assign w_shifted = blk_q << {idx_q, 3'b000};

    // Ready may follow m_ready combinationally so a new block can load on the final-byte edge.
    assign unpack_ready = !w_emit || (w_at_lim && m_ready);
    assign w_accept     = done && unpack_ready;

    assign m_data    = w_shifted[127:120];
    assign m_valid   = w_emit;
    assign m_last    = w_emit && frame_end_q && w_at_lim;
    assign busy      = w_emit;
    assign len_err   = len_err_q;
    assign block_cnt = block_cnt_q;

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        idx_d       = idx_q;
        lim_d       = lim_q;
        frame_end_d = frame_end_q;
        len_err_d   = len_err_q;
        block_cnt_d = block_cnt_q;

        if (w_xfer) begin
            if (w_at_lim) begin
                state_d = ST_IDLE;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end

        // Accept is evaluated after the transfer so a back-to-back load overrides the IDLE move.
        if (w_accept) begin
            state_d     = ST_EMIT;
            blk_d       = plaintext;
            idx_d       = 4'd0;
            lim_d       = (last_in && w_len_ok) ? w_nb_m1[3:0] : c_LIM_FULL;
            frame_end_d = last_in;
            block_cnt_d = block_cnt_q + c_CNT_ONE;
            if (last_in && !w_len_ok) begin
                len_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            blk_q       <= '0;
            idx_q       <= '0;
            lim_q       <= '0;
            frame_end_q <= 1'b0;
            len_err_q   <= 1'b0;
            block_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            idx_q       <= idx_d;
            lim_q       <= lim_d;
            frame_end_q <= frame_end_d;
            len_err_q   <= len_err_d;
            block_cnt_q <= block_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_block_unpack.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_block_unpack
// Brief   : Randomised self-checking bench for aes_block_unpack against a
//           byte-queue reference model.
// Revision: 1.0
// ============================================================================
module tb_aes_block_unpack;

    localparam int c_CNT_W = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [127:0]       plaintext = '0;
    logic               done = 1'b0;
    logic               last_in = 1'b0;
    logic [4:0]         nbytes_in = '0;
    logic               unpack_ready;
    logic [7:0]         m_data;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic               m_last;
    logic               busy;
    logic               len_err;
    logic [c_CNT_W-1:0] block_cnt;

    aes_block_unpack #(.CNT_W(c_CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .plaintext    (plaintext),
        .done         (done),
        .last_in      (last_in),
        .nbytes_in    (nbytes_in),
        .unpack_ready (unpack_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .busy         (busy),
        .len_err      (len_err),
        .block_cnt    (block_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: expected byte stream {last, data}, bytes left per held block.
    logic [8:0]         exp_q[$];
    int                 blen_q[$];
    logic [c_CNT_W-1:0] cnt_m = '0;
    logic               lerr_m = 1'b0;

    // Blocks waiting to be offered to the DUT.
    logic [127:0]       pend_d[$];
    logic               pend_l[$];
    logic [4:0]         pend_n[$];

    task automatic model_accept(input logic [127:0] d, input logic last, input logic [4:0] nb);
        int  len;
        bit  legal;
        legal = (nb >= 1) && (nb <= 16);
        len   = (last && legal) ? int'(nb) : 16;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(last && (i == len - 1)), d[127-8*i -: 8]});
        end
        blen_q.push_back(len);
        cnt_m = cnt_m + 1'b1;
        if (last && !legal) lerr_m = 1'b1;
    endtask

    task automatic queue_block(input logic [127:0] d, input logic last, input logic [4:0] nb);
        pend_d.push_back(d);
        pend_l.push_back(last);
        pend_n.push_back(nb);
    endtask

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0: m_ready always 1; mode 1: pattern 1,0,0; mode 2: random.
    task automatic stream(input string name, input int mode);
        int         cyc;
        bit         stall;
        logic [7:0] pd;
        logic       pl;
        logic       exp_v, exp_r, acc, xf;
        logic [8:0] e;
        cyc   = 0;
        stall = 0;
        pd    = '0;
        pl    = 1'b0;
        @(negedge clk);
        while ((pend_d.size() > 0 || exp_q.size() > 0) && cyc < 800) begin
            done = (pend_d.size() > 0);
            if (done) begin
                plaintext = pend_d[0];
                last_in   = pend_l[0];
                nbytes_in = pend_n[0];
            end else begin
                plaintext = rand_block();
                last_in   = 1'($urandom);
                nbytes_in = 5'($urandom);
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            exp_v = (exp_q.size() > 0);
            exp_r = (blen_q.size() == 0) || (blen_q[0] == 1 && m_ready);
            n_cmp++;
            if (m_valid !== exp_v || busy !== exp_v) begin
                n_err++;
                $display("FAIL %s valid cyc=%0d: m_valid=%b busy=%b expected %b", name, cyc, m_valid, busy, exp_v);
            end
            n_cmp++;
            if (unpack_ready !== exp_r) begin
                n_err++;
                $display("FAIL %s unpack_ready cyc=%0d: got %b expected %b", name, cyc, unpack_ready, exp_r);
            end
            n_cmp++;
            if (block_cnt !== cnt_m || len_err !== lerr_m) begin
                n_err++;
                $display("FAIL %s status cyc=%0d: block_cnt=%0d len_err=%b expected %0d/%b",
                         name, cyc, block_cnt, len_err, cnt_m, lerr_m);
            end
            if (exp_v) begin
                e = exp_q[0];
                n_cmp++;
                if (m_data !== e[7:0] || m_last !== e[8]) begin
                    n_err++;
                    $display("FAIL %s byte cyc=%0d: data=%h last=%b expected %h/%b",
                             name, cyc, m_data, m_last, e[7:0], e[8]);
                end
                if (stall) begin
                    n_cmp++;
                    if (m_data !== pd || m_last !== pl) begin
                        n_err++;
                        $display("FAIL %s stall_hold cyc=%0d: data=%h last=%b held %h/%b",
                                 name, cyc, m_data, m_last, pd, pl);
                    end
                end
            end
            stall = exp_v && !m_ready;
            pd    = m_data;
            pl    = m_last;
            xf    = exp_v && m_ready;
            acc   = done && exp_r;
            @(posedge clk);
            if (xf) begin
                void'(exp_q.pop_front());
                blen_q[0] = blen_q[0] - 1;
                if (blen_q[0] == 0) void'(blen_q.pop_front());
            end
            if (acc) begin
                model_accept(pend_d[0], pend_l[0], pend_n[0]);
                void'(pend_d.pop_front());
                void'(pend_l.pop_front());
                void'(pend_n.pop_front());
            end
            cyc++;
            @(negedge clk);
        end
        done = 1'b0;
        if (cyc >= 800) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: %0d bytes, %0d blocks still pending", name, exp_q.size(), pend_d.size());
            exp_q.delete();
            blen_q.delete();
            pend_d.delete();
            pend_l.delete();
            pend_n.delete();
        end
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || unpack_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s end_idle: m_valid=%b unpack_ready=%b expected 0/1", name, m_valid, unpack_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00 || busy !== 1'b0 ||
            len_err !== 1'b0 || block_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_values: valid=%b last=%b data=%h busy=%b len_err=%b cnt=%0d expected all 0",
                     m_valid, m_last, m_data, busy, len_err, block_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (unpack_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: unpack_ready=%b m_valid=%b expected 1/0", unpack_ready, m_valid);
        end
    endtask

    task automatic test_basic();
        queue_block(128'h00112233445566778899aabbccddeeff, 1'b0, 5'd3);
        stream("basic", 0);
    endtask

    task automatic test_final_block();
        queue_block(128'h00112233445566778899aabbccddeeff, 1'b1, 5'd5);
        stream("final_nb5", 0);
        queue_block(rand_block(), 1'b1, 5'd16);
        queue_block(rand_block(), 1'b1, 5'd1);
        stream("final_edges", 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) queue_block(rand_block(), 1'(i == 2), 5'($urandom_range(1, 16)));
        stream("backpressure", 1);
    endtask

    task automatic test_back_to_back();
        queue_block(rand_block(), 1'b0, 5'd0);
        queue_block(rand_block(), 1'b1, 5'd9);
        stream("back_to_back", 0);
    endtask

    task automatic test_len_err();
        queue_block(rand_block(), 1'b1, 5'd0);
        stream("len_err_0", 0);
        queue_block(rand_block(), 1'b1, 5'd17);
        queue_block(rand_block(), 1'b1, 5'd4);
        stream("len_err_17", 2);
    endtask

    task automatic test_random();
        logic       l;
        logic [4:0] nb;
        for (int i = 0; i < 20; i++) begin
            l  = 1'($urandom_range(0, 1));
            nb = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(1, 16));
            queue_block(rand_block(), l, nb);
        end
        stream("random", 2);
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        d = rand_block();
        @(negedge clk);
        plaintext = d;
        last_in   = 1'b0;
        nbytes_in = 5'd0;
        done      = 1'b1;
        m_ready   = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== d[71:64]) begin
            n_err++;
            $display("FAIL reset_mid byte7: valid=%b data=%h expected 1/%h", m_valid, m_data, d[71:64]);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || block_cnt !== '0 || len_err !== 1'b0 || m_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid async: valid=%b busy=%b cnt=%0d len_err=%b last=%b expected all 0",
                     m_valid, busy, block_cnt, len_err, m_last);
        end
        exp_q.delete();
        blen_q.delete();
        cnt_m  = '0;
        lerr_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        queue_block(rand_block(), 1'b1, 5'd12);
        stream("after_reset", 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_final_block();
        test_backpressure();
        test_back_to_back();
        test_len_err();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
